// File: rtl/la_clkgate_pkg.sv
// Shared types for the idle-detect clock-gating controller.
// State encoding and its width.
package la_clkgate_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    RUN   = 2'b00,
    GATED = 2'b01,
    WAKE  = 2'b10
  } state_e;

endpackage

// File: rtl/la_satcnt.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over increment.
module la_satcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // count up, hold at all-ones, clear wins
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/la_clkgate_ctrl.sv
// Idle-detect clock-gate enable controller.
// Registered gate_en/ack/gated; one shared idle/wake counter.
module la_clkgate_ctrl
  import la_clkgate_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CW          = 8,
  parameter int SW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          busy,
  input  logic          force_on,
  input  logic          stat_clr,
  output logic          gate_en,
  output logic          ack,
  output logic          gated,
  output logic [SW-1:0] stat_gated
);

  if ((IDLE_CYCLES >= (1 << CW)) ||
      (WAKE_CYCLES >= (1 << CW))) begin : g_bad_cfg
    $error("IDLE_CYCLES/WAKE_CYCLES must be < 2**CW");
  end

  localparam logic [CW-1:0] IDLE_TERM = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_TERM = CW'(WAKE_CYCLES - 1);

  state_e        r_state;
  state_e        w_nstate;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_ncnt;
  logic          r_gate_en;
  logic          r_ack;
  logic          r_gated;
  logic          w_act;
  logic          w_inc;

  assign w_act = req | busy | force_on;
  assign w_inc = (r_state == GATED);

  // next state and shared counter update
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    unique case (r_state)
      RUN: begin
        if (w_act || (IDLE_CYCLES == 0)) begin
          w_ncnt = '0;
        end else if (r_cnt == IDLE_TERM) begin
          w_nstate = GATED;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + CW'(1);
        end
      end
      GATED: begin
        if (w_act) begin
          w_ncnt   = '0;
          w_nstate = (WAKE_CYCLES == 0) ? RUN : WAKE;
        end
      end
      WAKE: begin
        if (r_cnt == WAKE_TERM) begin
          w_nstate = RUN;
          w_ncnt   = '0;
        end else begin
          w_ncnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_nstate = RUN;
        w_ncnt   = '0;
      end
    endcase
  end

  // state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_gate_en <= 1'b1;
      r_ack     <= 1'b0;
      r_gated   <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_cnt     <= w_ncnt;
      r_gate_en <= (w_nstate != GATED);
      r_ack     <= (w_nstate == RUN);
      r_gated   <= (w_nstate == GATED);
    end
  end

  la_satcnt #(.W(SW)) u_stat (
    .clk   (clk),
    .reset (reset),
    .i_clr (stat_clr),
    .i_inc (w_inc),
    .o_cnt (stat_gated)
  );

  assign gate_en = r_gate_en;
  assign ack     = r_ack;
  assign gated   = r_gated;

endmodule

// File: tb/tb_la_clkgate_ctrl.sv
// Directed bench for la_clkgate_ctrl.
// Four builds share one stimulus set.
module tb_la_clkgate_ctrl;

  logic clk = 1'b0;
  logic reset, req, busy, force_on, stat_clr;

  logic        ge0, ack0, gd0;
  logic [15:0] st0;
  logic        ge1, ack1, gd1;
  logic [15:0] st1;
  logic        ge2, ack2, gd2;
  logic [15:0] st2;
  logic        ge3, ack3, gd3;
  logic [3:0]  st3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  la_clkgate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2), .CW(8), .SW(16)) dut0 (
    .clk(clk), .reset(reset), .req(req), .busy(busy),
    .force_on(force_on), .stat_clr(stat_clr),
    .gate_en(ge0), .ack(ack0), .gated(gd0), .stat_gated(st0));

  la_clkgate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(0), .CW(8), .SW(16)) dut1 (
    .clk(clk), .reset(reset), .req(req), .busy(busy),
    .force_on(force_on), .stat_clr(stat_clr),
    .gate_en(ge1), .ack(ack1), .gated(gd1), .stat_gated(st1));

  la_clkgate_ctrl #(.IDLE_CYCLES(0), .WAKE_CYCLES(2), .CW(8), .SW(16)) dut2 (
    .clk(clk), .reset(reset), .req(req), .busy(busy),
    .force_on(force_on), .stat_clr(stat_clr),
    .gate_en(ge2), .ack(ack2), .gated(gd2), .stat_gated(st2));

  la_clkgate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .CW(8), .SW(4)) dut3 (
    .clk(clk), .reset(reset), .req(req), .busy(busy),
    .force_on(force_on), .stat_clr(stat_clr),
    .gate_en(ge3), .ack(ack3), .gated(gd3), .stat_gated(st3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 1'b0; busy = 1'b0; force_on = 1'b0; stat_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 1'b0; busy = 1'b0; force_on = 1'b0; stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({ge0, ack0, gd0} !== 3'b100 || st0 !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_hold: ge/ack/gd=%b st=%0d want 100 st=0",
                 {ge0, ack0, gd0}, st0);
      end
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (ack0 !== 1'b1 || ge0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_ack: ack=%b ge=%b want 1 1", ack0, ge0);
    end
    for (int i = 2; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        n_tests++;
        if (ge0 !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_ge_c15: ge=%b want 1", ge0);
        end
      end
    end
    n_tests++;
    if ({ge0, ack0, gd0} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_gate_c16: ge/ack/gd=%b want 001", {ge0, ack0, gd0});
    end
  endtask

  task automatic test_idle_restart();
    int early;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (ge0 !== 1'b1) early++;
    end
    n_tests++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL idle_restart_early: drops=%0d want 0", early);
    end
    tick();
    n_tests++;
    if (ge0 !== 1'b0 || gd0 !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_restart_c16: ge=%b gd=%b want 0 1", ge0, gd0);
    end
  endtask

  task automatic test_wake();
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (st0 !== 16'd4) begin
      n_fail++;
      $display("FAIL wake_stat_pre: st=%0d want 4", st0);
    end
    req = 1'b1;
    tick();
    n_tests++;
    if ({ge0, ack0, gd0} !== 3'b100 || st0 !== 16'd5) begin
      n_fail++;
      $display("FAIL wake_first: ge/ack/gd=%b st=%0d want 100 st=5",
               {ge0, ack0, gd0}, st0);
    end
    tick();
    n_tests++;
    if (ack0 !== 1'b0 || ge0 !== 1'b1) begin
      n_fail++;
      $display("FAIL wake_second: ack=%b ge=%b want 0 1", ack0, ge0);
    end
    tick();
    n_tests++;
    if (!(req === 1'b1 && ack0 === 1'b1) || st0 !== 16'd5) begin
      n_fail++;
      $display("FAIL wake_xfer: ack=%b st=%0d want 1 st=5", ack0, st0);
    end
    req = 1'b0;
  endtask

  task automatic test_wake0();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (ge1 !== 1'b0 || gd1 !== 1'b1) begin
      n_fail++;
      $display("FAIL wake0_gated: ge=%b gd=%b want 0 1", ge1, gd1);
    end
    req = 1'b1;
    tick();
    n_tests++;
    if ({ge1, ack1, gd1} !== 3'b110) begin
      n_fail++;
      $display("FAIL wake0_run: ge/ack/gd=%b want 110", {ge1, ack1, gd1});
    end
    req = 1'b0;
  endtask

  task automatic test_activity_wins();
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    n_tests++;
    if (ge1 !== 1'b1 || gd1 !== 1'b0) begin
      n_fail++;
      $display("FAIL act_wins_term: ge=%b gd=%b want 1 0", ge1, gd1);
    end
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (ge1 !== 1'b1) begin
      n_fail++;
      $display("FAIL act_wins_c3: ge=%b want 1", ge1);
    end
    tick();
    n_tests++;
    if (ge1 !== 1'b0) begin
      n_fail++;
      $display("FAIL act_wins_c4: ge=%b want 0", ge1);
    end
  endtask

  task automatic test_force_on();
    int drops;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    force_on = 1'b1;
    tick();
    n_tests++;
    if ({ge1, ack1} !== 2'b11) begin
      n_fail++;
      $display("FAIL force_wake: ge/ack=%b want 11", {ge1, ack1});
    end
    drops = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ge1 !== 1'b1) drops++;
    end
    n_tests++;
    if (drops !== 0) begin
      n_fail++;
      $display("FAIL force_hold: drops=%0d want 0", drops);
    end
    force_on = 1'b0;
  endtask

  task automatic test_idle0();
    int drops;
    do_reset();
    drops = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (ge2 !== 1'b1 || gd2 !== 1'b0) drops++;
    end
    n_tests++;
    if (drops !== 0 || ack2 !== 1'b1) begin
      n_fail++;
      $display("FAIL idle0: drops=%0d ack=%b want 0 1", drops, ack2);
    end
  endtask

  task automatic test_reset_mid_wake();
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    req = 1'b1;
    tick();
    n_tests++;
    if ({ge0, ack0} !== 2'b10 || st0 !== 16'd1) begin
      n_fail++;
      $display("FAIL rmw_wake: ge/ack=%b st=%0d want 10 st=1",
               {ge0, ack0}, st0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if ({ge0, ack0, gd0} !== 3'b100 || st0 !== 16'd0) begin
      n_fail++;
      $display("FAIL rmw_reset: ge/ack/gd=%b st=%0d want 100 st=0",
               {ge0, ack0, gd0}, st0);
    end
    tick();
    n_tests++;
    if (ack0 !== 1'b1 || ge0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_release: ack=%b ge=%b want 1 1", ack0, ge0);
    end
    req = 1'b0;
  endtask

  task automatic test_sat_clr();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 20; i++) tick();
    n_tests++;
    if (st3 !== 4'd15 || gd3 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat: st=%0d gd=%b want 15 1", st3, gd3);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    n_tests++;
    if (st3 !== 4'd0) begin
      n_fail++;
      $display("FAIL clr: st=%0d want 0", st3);
    end
    tick();
    n_tests++;
    if (st3 !== 4'd1) begin
      n_fail++;
      $display("FAIL clr_resume1: st=%0d want 1", st3);
    end
    tick();
    n_tests++;
    if (st3 !== 4'd2) begin
      n_fail++;
      $display("FAIL clr_resume2: st=%0d want 2", st3);
    end
  endtask

  initial begin
    test_reset();
    test_idle_restart();
    test_wake();
    test_wake0();
    test_activity_wins();
    test_force_on();
    test_idle0();
    test_reset_mid_wake();
    test_sat_clr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/la_clkgate_ctrl.md
Name: la_clkgate_ctrl

Overview:
- Idle-detect clock-gating controller. Produces the enable for an integrated clock-gate cell whose enable is captured by an active-low transparent latch.
- Runs on the free-running (ungated) clk.
- Watches downstream activity, drops the gate enable after a programmable idle period, and restores it on request.
- Gives requesters a req/ack handshake so no transaction is issued while the gated domain is off or still waking.

Parameters:
- IDLE_CYCLES, 16: consecutive inactive cycles in RUN before gating. 0 disables gating; the block stays in RUN permanently.
- WAKE_CYCLES, 2: cycles between gate_en rising and ack rising. 0 means GATED goes directly to RUN.
- CW, 8: idle/wake counter width. IDLE_CYCLES and WAKE_CYCLES must each be < 2^CW; violation raises an elaboration error.
- SW, 16: width of the gated-cycle statistics counter.

Ports:
- clk  input  1  free-running clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  activity request from an initiator; held high until ack is seen
- busy  input  1  downstream gated domain still active (e.g. pipeline not drained)
- force_on  input  1  debug/test override; keeps or brings the clock on
- stat_clr  input  1  synchronous clear of stat_gated
- gate_en  output  1  enable to the clock-gate cell; registered
- ack  output  1  gated clock is running and stable; req may proceed
- gated  output  1  high while in GATED
- stat_gated  output  SW  saturating count of cycles spent in GATED

Behaviour:
- Reset (while reset=1, registered):
  - state=RUN, idle_cnt=0, wake_cnt=0
  - gate_en=1, ack=0, gated=0, stat_gated=0
- First cycle after reset falls: ack=1.
- gate_en, ack and gated are flop outputs, never combinational from inputs. gate_en changes only at the rising edge, so it is stable through the low phase when the cell latch is transparent.
- act = req | busy | force_on.
- RUN: gate_en=1, ack=1, gated=0.
  - act=1: idle_cnt<=0.
  - act=0 and idle_cnt==IDLE_CYCLES-1: go to GATED. Next cycle gate_en=0, ack=0, gated=1.
  - Otherwise with act=0: idle_cnt increments.
  - So gate_en falls exactly IDLE_CYCLES cycles after the last active cycle.
  - IDLE_CYCLES=0: never leaves RUN.
- GATED: gate_en=0, ack=0, gated=1; stat_gated increments, saturating at 2^SW-1.
  - act=1: go to WAKE with wake_cnt<=0. Next cycle gate_en=1, gated=0.
  - If WAKE_CYCLES=0, go directly to RUN instead; ack=1 with gate_en=1 in the same cycle.
- WAKE: gate_en=1, ack=0.
  - wake_cnt increments each cycle.
  - When wake_cnt==WAKE_CYCLES-1: go to RUN with idle_cnt<=0.
  - ack therefore rises WAKE_CYCLES cycles after gate_en rises.
  - act is ignored here; wake completes even if req drops.
- Handshake: a transfer occurs on a cycle with req=1 and ack=1. A req that arrives in GATED or WAKE is held by the initiator and completes on the first RUN cycle.
- Simultaneous events:
  - act=1 on the same cycle idle_cnt reaches terminal: stays RUN, counter resets. Activity wins.
  - stat_clr and an increment on the same cycle: result is 0. Clear wins.
- reset=1 in any state (including mid-WAKE or GATED): next cycle is RUN with gate_en=1, ack=0.
- stat_clr is independent of state; reset also clears stat_gated.
- Unreachable state encodings recover to RUN with gate_en=1.

Decomposition:
- Shared package la_clkgate_pkg holds:
  - state enum: RUN=2'b00, GATED=2'b01, WAKE=2'b10
  - the 2-bit state width constant
- One natural sub-module: la_satcnt, a saturating up-counter with clear, parameterized width. Used for stat_gated.
- idle_cnt and wake_cnt share a single CW-bit counter register, because the two are never live in the same state.

Test Plan:
- Reset with IDLE_CYCLES=16: hold reset 3 cycles, then release with act=0 -> during reset gate_en=1 and ack=0. Cycle 1 after release ack=1. gate_en falls 16 cycles after release; gated=1 from that same cycle.
- Idle restart: act=0 for 10 cycles, busy=1 for 1 cycle, then act=0 -> gate_en stays 1 and falls exactly 16 cycles after the busy pulse.
- Wake handshake, WAKE_CYCLES=2: in GATED, raise req and hold it -> next cycle gate_en=1, ack=0. ack=1 two cycles later; transfer counted on that cycle. stat_gated equals the GATED dwell.
- WAKE_CYCLES=0 and IDLE_CYCLES=0 builds:
  - WAKE_CYCLES=0: req in GATED gives gate_en=1 and ack=1 on the next cycle.
  - IDLE_CYCLES=0: gate_en never falls over 1000 idle cycles.
- Reset mid-WAKE: assert reset on the first WAKE cycle -> next cycle gate_en=1, ack=0, stat_gated=0. After release, ack=1.
- Saturation and clear, SW=4: stay in GATED 20 cycles -> stat_gated holds 15. Pulse stat_clr on a GATED cycle -> stat_gated=0 next cycle, then resumes counting 1, 2, ...
